// File: rtl/f_adder_sched.sv
// Issue scheduler for the shared FP adder: arbitrates two requesters, tracks a
// shadow copy of per-stage occupancy, and hands completed results to writeback.
module f_adder_sched #(
    parameter int TAG_W = 4,
    parameter int LAT   = 4,
    parameter bit RR_EN = 1'b1,
    localparam int CNT_W = $clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             fa_sel,
    output logic [TAG_W+1:0] fa_info,
    input  logic [TAG_W+1:0] fa_info_out,
    output logic             fa_wait,
    output logic             fa_flush,
    output logic             wb_valid,
    output logic             wb_src,
    output logic [TAG_W-1:0] wb_tag,
    output logic [CNT_W-1:0] inflight,
    output logic             idle,
    output logic             mismatch
);
    typedef struct packed {
        logic             vld;
        logic             src;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t [LAT-1:0] stg_q, stg_d;
    stage_t           head, issued;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             mismatch_q, mismatch_d;
    logic             gnt0, gnt1, any_gnt, can_grant;

    // Only the valid bit of the adder's info_out is cross-checked.
    logic unused_info_out;
    assign unused_info_out = ^fa_info_out[TAG_W+1:1];

    always_comb begin
        head     = stg_q[LAT-1];
        fa_flush = flush;
        wb_valid = head.vld & ~flush;
        wb_src   = head.src;
        wb_tag   = head.tag;
        fa_wait  = head.vld & ~wb_ready & ~flush;

        // Grant is gated by resetn so nothing is accepted while held in reset.
        can_grant = resetn & ~fa_wait & ~flush;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_grant) begin
            if (req0_valid && req1_valid) begin
                if (RR_EN) begin
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        any_gnt    = gnt0 | gnt1;
        req0_ready = gnt0;
        req1_ready = gnt1;

        issued = '0;
        if (any_gnt) begin
            issued.vld = 1'b1;
            issued.src = gnt1;
            issued.tag = gnt1 ? req1_tag : req0_tag;
        end
        fa_info = {issued.tag, issued.src, issued.vld};
        fa_sel  = any_gnt ? gnt1 : sel_q;
        sel_d   = fa_sel;
        last_d  = any_gnt ? gnt1 : last_q;

        stg_d = stg_q;
        if (flush) begin
            stg_d = '0;
        end else if (!fa_wait) begin
            stg_d[0] = issued;
            for (int k = 1; k < LAT; k++) stg_d[k] = stg_q[k-1];
        end

        mismatch_d = mismatch_q | (~flush & ~fa_wait & (head.vld != fa_info_out[0]));
        mismatch   = mismatch_q;

        inflight = '0;
        for (int k = 0; k < LAT; k++) inflight = inflight + CNT_W'(stg_q[k].vld);
        idle = (inflight == '0) & ~any_gnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_q      <= '0;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            stg_q      <= stg_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            mismatch_q <= mismatch_d;
        end
    end
endmodule

// File: tb/tb_f_adder_sched.sv
// Directed bench for f_adder_sched: arbitration, latency, backpressure, flush,
// and the shadow/adder consistency flag, with a behavioural adder delay line.
module tb_f_adder_sched;
    localparam int TAG_W = 4;
    localparam int LAT   = 4;
    localparam int IW    = TAG_W + 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             req0_valid, req1_valid;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             req0_ready, req1_ready;
    logic             flush, wb_ready;
    logic             fa_sel;
    logic [IW-1:0]    fa_info, fa_info_out;
    logic             fa_wait, fa_flush;
    logic             wb_valid, wb_src;
    logic [TAG_W-1:0] wb_tag;
    logic [2:0]       inflight;
    logic             idle, mismatch;
    logic             corrupt;

    // fixed-priority instance, only its grants are examined
    logic             p_r0, p_r1, p_sel, p_wait, p_fl, p_wbv, p_wbs, p_idle, p_mm;
    logic [IW-1:0]    p_info;
    logic [TAG_W-1:0] p_wbt;
    logic [2:0]       p_inf;

    int checks = 0;
    int failures = 0;

    logic [LAT-1:0][IW-1:0] apipe;

    always #5 clk = ~clk;

    f_adder_sched #(.TAG_W(TAG_W), .LAT(LAT), .RR_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_tag(req0_tag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_tag(req1_tag), .req1_ready(req1_ready),
        .flush(flush), .wb_ready(wb_ready), .fa_sel(fa_sel), .fa_info(fa_info),
        .fa_info_out(fa_info_out), .fa_wait(fa_wait), .fa_flush(fa_flush),
        .wb_valid(wb_valid), .wb_src(wb_src), .wb_tag(wb_tag),
        .inflight(inflight), .idle(idle), .mismatch(mismatch)
    );

    f_adder_sched #(.TAG_W(TAG_W), .LAT(LAT), .RR_EN(1'b0)) u_fp (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_tag(req0_tag), .req0_ready(p_r0),
        .req1_valid(req1_valid), .req1_tag(req1_tag), .req1_ready(p_r1),
        .flush(flush), .wb_ready(wb_ready), .fa_sel(p_sel), .fa_info(p_info),
        .fa_info_out(fa_info_out), .fa_wait(p_wait), .fa_flush(p_fl),
        .wb_valid(p_wbv), .wb_src(p_wbs), .wb_tag(p_wbt),
        .inflight(p_inf), .idle(p_idle), .mismatch(p_mm)
    );

    // Behavioural adder: LAT-deep info delay line honouring wait and flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       apipe <= '0;
        else if (fa_flush) apipe <= '0;
        else if (!fa_wait) apipe <= {apipe[LAT-2:0], fa_info};
    end
    assign fa_info_out = apipe[LAT-1] ^ {{(IW-1){1'b0}}, corrupt};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req0_tag = 4'd3;
        #2;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (fa_wait !== 1'b0) begin failures++; $display("FAIL rst_fa_wait got=%0b exp=0", fa_wait); end
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_req0_ready got=%0b exp=0", req0_ready); end
        checks++; if (fa_info !== 6'h00) begin failures++; $display("FAIL rst_fa_info got=%h exp=00", fa_info); end
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL rst_mismatch got=%0b exp=0", mismatch); end
        req0_valid = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_tag = 4'd5;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", req0_ready); end
        checks++; if (fa_info !== 6'h15) begin failures++; $display("FAIL single_fa_info got=%h exp=15", fa_info); end
        checks++; if (fa_sel !== 1'b0) begin failures++; $display("FAIL single_fa_sel got=%0b exp=0", fa_sel); end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            req0_valid = 1'b0;
            #1;
            if (i < 4) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL single_early_wb cyc=%0d got=%0b exp=0", i, wb_valid); end
            end else begin
                checks++; if ({wb_valid, wb_src, wb_tag} !== {1'b1, 1'b0, 4'd5})
                    begin failures++; $display("FAIL single_wb got=%0b/%0b/%0d exp=1/0/5", wb_valid, wb_src, wb_tag); end
                checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL single_inflight got=%0d exp=1", inflight); end
            end
        end
        cyc();
        checks++; if (wb_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL single_idle got=wb%0b/idle%0b exp=wb0/idle1", wb_valid, idle); end
    endtask

    task automatic test_contention();
        logic e;
        reset_pulse();
        req0_tag = 4'd1; req1_tag = 4'd2;
        for (int j = 0; j < 11; j++) begin
            req0_valid = (j < 6);
            req1_valid = (j < 6);
            #1;
            if (j < 6) begin
                e = (j % 2 == 1);
                checks++; if ({req1_ready, req0_ready, fa_sel} !== {e, ~e, e})
                    begin failures++; $display("FAIL rr_grant j=%0d got=r1%0b/r0%0b/sel%0b exp_idx=%0b", j, req1_ready, req0_ready, fa_sel, e); end
                checks++; if ({p_r0, p_r1} !== 2'b10)
                    begin failures++; $display("FAIL fixed_grant j=%0d got=r0%0b/r1%0b exp=r0=1/r1=0", j, p_r0, p_r1); end
            end
            if (j >= 4 && j < 10) begin
                e = ((j - 4) % 2 == 1);
                checks++; if ({wb_valid, wb_src, wb_tag} !== {1'b1, e, e ? 4'd2 : 4'd1})
                    begin failures++; $display("FAIL rr_wb j=%0d got=%0b/%0b/%0d exp_src=%0b", j, wb_valid, wb_src, wb_tag, e); end
            end else begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rr_wb_idle j=%0d got=%0b exp=0", j, wb_valid); end
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_tag;
        for (int j = 0; j < 13; j++) begin
            req0_valid = (j < 4) || (j >= 4 && j <= 7);
            req0_tag   = (j < 4) ? 4'(3 + j) : 4'd7;
            wb_ready   = !(j >= 4 && j <= 6);
            #1;
            if (j >= 4 && j <= 6) begin
                checks++; if ({fa_wait, req0_ready, wb_valid} !== 3'b101)
                    begin failures++; $display("FAIL bp_stall j=%0d got=wait%0b/rdy%0b/wbv%0b exp=1/0/1", j, fa_wait, req0_ready, wb_valid); end
                checks++; if (inflight !== 3'd4) begin failures++; $display("FAIL bp_inflight j=%0d got=%0d exp=4", j, inflight); end
            end
            if (j == 7) begin
                checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_grant got=%0b exp=1", req0_ready); end
            end
            if (j >= 7 && j <= 11) begin
                exp_tag = 4'(j - 4);
                checks++; if ({wb_valid, wb_src, wb_tag} !== {1'b1, 1'b0, exp_tag})
                    begin failures++; $display("FAIL bp_drain j=%0d got=%0b/%0b/%0d exp=1/0/%0d", j, wb_valid, wb_src, wb_tag, exp_tag); end
            end
            if (j == 12) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_wb got=%0b exp=0", wb_valid); end
            end
            cyc();
        end
        req0_valid = 1'b0; wb_ready = 1'b1;
    endtask

    task automatic test_flush();
        for (int j = 0; j < 3; j++) begin
            req0_valid = 1'b1; req0_tag = 4'(8 + j);
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_tag = 4'd11; flush = 1'b1;
        #1;
        checks++; if ({req1_ready, wb_valid, fa_flush, fa_info} !== {3'b001, 6'h00})
            begin failures++; $display("FAIL flush_cycle got=r1%0b/wbv%0b/ff%0b/info%h exp=0/0/1/00", req1_ready, wb_valid, fa_flush, fa_info); end
        cyc();
        flush = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL flush_inflight got=%0d exp=0", inflight); end
        for (int j = 4; j < 10; j++) begin
            req1_valid = (j == 5); req1_tag = 4'd12;
            #1;
            if (j == 5) begin
                checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL flush_newreq got=%0b exp=1", req1_ready); end
            end
            if (j < 9) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_wb j=%0d got=%0b exp=0", j, wb_valid); end
            end else begin
                checks++; if ({wb_valid, wb_src, wb_tag} !== {1'b1, 1'b1, 4'd12})
                    begin failures++; $display("FAIL flush_new_wb got=%0b/%0b/%0d exp=1/1/12", wb_valid, wb_src, wb_tag); end
            end
            cyc();
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_flush_stall();
        req0_valid = 1'b1; req0_tag = 4'd13;
        cyc();
        req0_valid = 1'b0;
        cyc(); cyc(); cyc();
        wb_ready = 1'b0;
        #1;
        checks++; if (fa_wait !== 1'b1) begin failures++; $display("FAIL fs_prestall got=%0b exp=1", fa_wait); end
        flush = 1'b1;
        #1;
        checks++; if ({fa_wait, fa_flush, wb_valid} !== 3'b010)
            begin failures++; $display("FAIL fs_flush got=wait%0b/ff%0b/wbv%0b exp=0/1/0", fa_wait, fa_flush, wb_valid); end
        cyc();
        flush = 1'b0; wb_ready = 1'b1;
        #1;
        checks++; if ({inflight, wb_valid} !== 4'b0000)
            begin failures++; $display("FAIL fs_cleared got=inf%0d/wbv%0b exp=0/0", inflight, wb_valid); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_tag = 4'd9;
        cyc();
        req0_valid = 1'b0;
        cyc();
        resetn = 1'b0;
        #1;
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL midrst_inflight got=%0d exp=0", inflight); end
        cyc();
        resetn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_wb j=%0d got=%0b exp=0", j, wb_valid); end
            cyc();
        end
    endtask

    task automatic test_mismatch();
        #1;
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL mm_initial got=%0b exp=0", mismatch); end
        corrupt = 1'b1;
        cyc();
        corrupt = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_sticky j=%0d got=%0b exp=1", j, mismatch); end
            cyc();
        end
        resetn = 1'b0;
        #1;
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL mm_reset got=%0b exp=0", mismatch); end
        cyc();
        resetn = 1'b1;
        cyc();
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL mm_after_reset got=%0b exp=0", mismatch); end
    endtask

    initial begin
        resetn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_tag = '0; req1_tag = '0; flush = 1'b0; wb_ready = 1'b1; corrupt = 1'b0;
        cyc();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        test_mismatch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
